// File: rtl/sipo_deser.sv
// sipo_deser: serial-in/parallel-out deserializer for the 4-bit PISO stream.
// Valid-qualified bits are collected in a shift register. Each completed word
// moves into a one-entry holding register that drains through a valid/ready
// handshake. A completed word that finds the holding register busy is dropped,
// and this sets the sticky overrun flag.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no partial word; bit_cnt = 0
// SHIFT | partial word in progress; bit_cnt = 1..WIDTH-1
module sipo_deser #(
   parameter int WIDTH     = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sin,
   input  logic                     sin_valid,
   input  logic                     clear,
   output logic [WIDTH-1:0]         dout,
   output logic                     dout_valid,
   input  logic                     dout_ready,
   output logic                     overrun,
   output logic [$clog2(WIDTH):0]   bit_cnt
);

   localparam int            CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_nxt;
   logic             drain;
   logic             last_bit;

   // Next shift-register contents with the incoming bit merged in the configured direction.
   always_comb begin
      shreg_nxt = shreg;
      if (MSB_FIRST != 0) shreg_nxt = {shreg[WIDTH-2:0], sin};
      else                shreg_nxt = {sin, shreg[WIDTH-1:1]};
   end

   assign drain    = dout_valid & dout_ready;
   assign last_bit = (bit_cnt == LAST);

   // Collection FSM, holding register and overrun flag. A completion on the
   // same edge as a drain overrides the drain, so dout_valid stays high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (drain) dout_valid <= 1'b0;
         if (clear) begin
            state   <= IDLE;
            bit_cnt <= '0;
            overrun <= 1'b0;
         end else if (sin_valid) begin
            shreg <= shreg_nxt;
            case (state)
               IDLE: begin
                  state   <= SHIFT;
                  bit_cnt <= CW'(1);
               end
               SHIFT: begin
                  if (last_bit) begin
                     state   <= IDLE;
                     bit_cnt <= '0;
                     if (!dout_valid || dout_ready) begin
                        dout       <= shreg_nxt;
                        dout_valid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + CW'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sipo_deser.sv
// Testbench for sipo_deser: a fixed vector table, hand-written corner
// sequences and random traffic, compared against a queue-based word model.
module tb_sipo_deser;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         sin = 1'b0;
   logic         sin_valid = 1'b0;
   logic         clear = 1'b0;
   logic         dout_ready = 1'b0;
   logic [W-1:0] dout_m, dout_l;
   logic         dv_m, dv_l, ovr_m, ovr_l;
   logic [2:0]   cnt_m, cnt_l;

   int tests = 0;
   int fails = 0;

   sipo_deser #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
      .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .clear(clear),
      .dout(dout_m), .dout_valid(dv_m), .dout_ready(dout_ready),
      .overrun(ovr_m), .bit_cnt(cnt_m));

   sipo_deser #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
      .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .clear(clear),
      .dout(dout_l), .dout_valid(dv_l), .dout_ready(dout_ready),
      .overrun(ovr_l), .bit_cnt(cnt_l));

   always #5 clk = ~clk;

   // reference model: received bits of the partial word plus the holding register
   int           part[$];
   logic [W-1:0] m_dout_m, m_dout_l;
   logic         m_valid, m_ovr;

   task automatic model_reset();
      part.delete();
      m_dout_m = '0; m_dout_l = '0; m_valid = 1'b0; m_ovr = 1'b0;
   endtask

   task automatic model_step(input logic s, input logic v, input logic c, input logic r);
      logic         drain, done;
      logic [W-1:0] wm, wl;
      drain = m_valid && r;
      done  = 1'b0;
      if (c) begin
         part.delete();
         m_ovr = 1'b0;
      end else if (v) begin
         part.push_back(int'(s));
         if (part.size() == W) begin
            done = 1'b1;
            wm = '0; wl = '0;
            for (int i = 0; i < W; i++) begin
               if (part[i] != 0) begin
                  wm = wm | (W'(1) << (W - 1 - i));
                  wl = wl | (W'(1) << i);
               end
            end
            if (!m_valid || r) begin
               m_dout_m = wm; m_dout_l = wl; m_valid = 1'b1;
            end else begin
               m_ovr = 1'b1;
            end
            part.delete();
         end
      end
      if (drain && !done) m_valid = 1'b0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_model();
      chk("model dout msb", 32'(dout_m), 32'(m_dout_m));
      chk("model dout lsb", 32'(dout_l), 32'(m_dout_l));
      chk("model valid",    32'(dv_m),   32'(m_valid));
      chk("model valid lsb",32'(dv_l),   32'(m_valid));
      chk("model overrun",  32'(ovr_m),  32'(m_ovr));
      chk("model cnt",      32'(cnt_m),  32'(part.size()));
      chk("model cnt lsb",  32'(cnt_l),  32'(part.size()));
   endtask

   // one clock: drive at negedge, model at posedge, compare at next negedge
   task automatic cycle(input logic s, input logic v, input logic c, input logic r);
      sin = s; sin_valid = v; clear = c; dout_ready = r;
      @(posedge clk);
      model_step(s, v, c, r);
      @(negedge clk);
      chk_model();
   endtask

   typedef struct {
      logic         s, v, c, r;
      logic [W-1:0] d;
      logic         dv, ov;
      logic [2:0]   cnt;
   } vec_t;

   vec_t tbl[$];

   initial begin
      logic [W-1:0] pat;
      logic [3:0]   stream;
      // s v c r | dout dv ov cnt   (dout is the MSB-first instance)
      tbl.push_back('{1,1,0,1, 4'b0000,0,0,1});
      tbl.push_back('{0,1,0,1, 4'b0000,0,0,2});
      tbl.push_back('{1,1,0,1, 4'b0000,0,0,3});
      tbl.push_back('{1,1,0,1, 4'b1011,1,0,0});
      tbl.push_back('{0,0,0,1, 4'b1011,0,0,0});
      tbl.push_back('{1,1,0,0, 4'b1011,0,0,1});
      tbl.push_back('{1,1,0,0, 4'b1011,0,0,2});
      tbl.push_back('{0,1,0,0, 4'b1011,0,0,3});
      tbl.push_back('{0,1,0,0, 4'b1100,1,0,0});
      tbl.push_back('{0,1,0,0, 4'b1100,1,0,1});
      tbl.push_back('{0,1,0,0, 4'b1100,1,0,2});
      tbl.push_back('{1,1,0,0, 4'b1100,1,0,3});
      tbl.push_back('{1,1,0,0, 4'b1100,1,1,0});
      tbl.push_back('{0,0,0,1, 4'b1100,0,1,0});
      tbl.push_back('{0,0,1,0, 4'b1100,0,0,0});
      tbl.push_back('{1,1,0,1, 4'b1100,0,0,1});
      tbl.push_back('{1,1,0,1, 4'b1100,0,0,2});
      tbl.push_back('{1,1,1,1, 4'b1100,0,0,0});
      tbl.push_back('{1,1,0,1, 4'b1100,0,0,1});
      tbl.push_back('{1,1,0,1, 4'b1100,0,0,2});
      tbl.push_back('{1,1,0,1, 4'b1100,0,0,3});
      tbl.push_back('{1,1,0,1, 4'b1111,1,0,0});
      tbl.push_back('{0,0,1,1, 4'b1111,0,0,0});
      tbl.push_back('{0,1,0,0, 4'b1111,0,0,1});
      tbl.push_back('{1,1,0,0, 4'b1111,0,0,2});
      tbl.push_back('{0,1,0,0, 4'b1111,0,0,3});
      tbl.push_back('{1,1,0,0, 4'b0101,1,0,0});
      tbl.push_back('{0,1,0,0, 4'b0101,1,0,1});
      tbl.push_back('{1,1,0,0, 4'b0101,1,0,2});
      tbl.push_back('{1,1,0,0, 4'b0101,1,0,3});
      tbl.push_back('{0,1,0,1, 4'b0110,1,0,0});
      tbl.push_back('{0,0,0,1, 4'b0110,0,0,0});

      model_reset();
      #1;
      chk("reset dout",    32'(dout_m), 0);
      chk("reset valid",   32'(dv_m),   0);
      chk("reset overrun", 32'(ovr_m),  0);
      chk("reset cnt",     32'(cnt_m),  0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      cycle(0, 0, 0, 0);
      cycle(1, 0, 0, 1);
      chk("idle dout",  32'(dout_m), 0);
      chk("idle valid", 32'(dv_m),   0);

      // vector table
      foreach (tbl[i]) begin
         cycle(tbl[i].s, tbl[i].v, tbl[i].c, tbl[i].r);
         chk($sformatf("vec%0d dout", i),  32'(dout_m), 32'(tbl[i].d));
         chk($sformatf("vec%0d valid", i), 32'(dv_m),   32'(tbl[i].dv));
         chk($sformatf("vec%0d ovr", i),   32'(ovr_m),  32'(tbl[i].ov));
         chk($sformatf("vec%0d cnt", i),   32'(cnt_m),  32'(tbl[i].cnt));
      end

      // 1,0,1,1 with gaps of 0..3 idle cycles between bits
      stream = 4'b1011;
      for (int g = 0; g < 4; g++) begin
         for (int b = 3; b >= 0; b--) begin
            cycle(stream[b], 1, 0, 1);
            if (b != 0) for (int k = 0; k < g; k++) cycle($urandom_range(0, 1), 0, 0, 1);
         end
         chk($sformatf("gap%0d msb", g), 32'(dout_m), 32'hB);
         chk($sformatf("gap%0d lsb", g), 32'(dout_l), 32'hD);
         chk($sformatf("gap%0d valid", g), 32'(dv_m), 1);
      end

      // back-to-back words with ready high, then async reset after bit 3
      for (int w = 0; w < 3; w++) begin
         pat = W'($urandom);
         for (int b = W - 1; b >= 0; b--) begin
            cycle(pat[b], 1, 0, 1);
            chk("b2b valid", 32'(dv_m), (b == 0) ? 1 : (w == 0 ? 0 : 0));
         end
         chk("b2b word", 32'(dout_m), 32'(pat));
      end
      cycle(1, 1, 0, 0);
      cycle(0, 1, 0, 0);
      cycle(1, 1, 0, 0);
      chk("pre-reset cnt", 32'(cnt_m), 3);
      #2 rst = 1'b0;
      #1;
      chk("async dout",  32'(dout_m), 0);
      chk("async valid", 32'(dv_m),   0);
      chk("async ovr",   32'(ovr_m),  0);
      chk("async cnt",   32'(cnt_m),  0);
      @(negedge clk);
      chk("held reset cnt", 32'(cnt_m), 0);
      rst = 1'b1;
      model_reset();
      cycle(1, 1, 0, 1);
      chk("post-reset cnt", 32'(cnt_m), 1);

      // random PISO-style traffic
      for (int n = 0; n < 3000; n++) begin
         cycle($urandom_range(0, 1),
               ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 99) < 3),
               ($urandom_range(0, 1) == 1));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
